// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced button level into short-press,
// long-press and auto-repeat pulses, advancing only on the shared sample tick.
module button_event_decoder #(
    parameter int unsigned LONG_TICKS   = 500,
    parameter int unsigned REPEAT_TICKS = 100
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ena,
    input  logic i_btn,
    output logic o_short,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    typedef enum logic [1:0] {
        StArm,
        StIdle,
        StPress,
        StRepeat
    } state_e;

    // Terminal counts, sized to the 16-bit hold counter.
    localparam logic [15:0] LongLast   = 16'(LONG_TICKS - 1);
    localparam logic [15:0] RepeatLast = 16'(REPEAT_TICKS - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        short_q, short_d;
    logic        long_q, long_d;
    logic        repeat_q, repeat_d;

    // Next-state, counter and pulse decode; everything holds between ticks.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        if (i_ena) begin
            unique case (state_q)
                // Wait for a released sample so a button held through reset is ignored.
                StArm: begin
                    if (!i_btn) begin
                        state_d = StIdle;
                    end
                end
                StIdle: begin
                    if (i_btn) begin
                        state_d = StPress;
                        cnt_d   = 16'd1;
                    end
                end
                // Release is tested first so it wins over the threshold tick.
                StPress: begin
                    if (!i_btn) begin
                        short_d = 1'b1;
                        state_d = StIdle;
                        cnt_d   = 16'd0;
                    end else if (cnt_q >= LongLast) begin
                        long_d  = 1'b1;
                        state_d = StRepeat;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StRepeat: begin
                    if (!i_btn) begin
                        state_d = StIdle;
                        cnt_d   = 16'd0;
                    end else if (cnt_q >= RepeatLast) begin
                        repeat_d = 1'b1;
                        cnt_d    = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = StArm;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // State, counter and registered pulse outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StArm;
            cnt_q    <= 16'd0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    assign o_short  = short_q;
    assign o_long   = long_q;
    assign o_repeat = repeat_q;
    assign o_held   = (state_q == StRepeat);

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: directed scenarios followed by
// randomized presses, compared every clock against a hold-length model.
module tb_button_event_decoder;

    localparam int LongTicks   = 4;
    localparam int RepeatTicks = 2;

    logic i_clk;
    logic i_rst_n;
    logic i_ena;
    logic i_btn;
    logic o_short;
    logic o_long;
    logic o_repeat;
    logic o_held;

    int n_checks;
    int n_errors;

    // Model: armed once a low sample is seen; hold_n counts held ticks of the current press.
    bit m_armed;
    int hold_n;
    bit e_short;
    bit e_long;
    bit e_repeat;
    bit e_held;

    button_event_decoder #(
        .LONG_TICKS  (LongTicks),
        .REPEAT_TICKS(RepeatTicks)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ena   (i_ena),
        .i_btn   (i_btn),
        .o_short (o_short),
        .o_long  (o_long),
        .o_repeat(o_repeat),
        .o_held  (o_held)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".short"}, int'(o_short), int'(e_short));
        check_val({tag, ".long"}, int'(o_long), int'(e_long));
        check_val({tag, ".repeat"}, int'(o_repeat), int'(e_repeat));
        check_val({tag, ".held"}, int'(o_held), int'(e_held));
    endtask

    task automatic model_reset();
        m_armed  = 1'b0;
        hold_n   = 0;
        e_short  = 1'b0;
        e_long   = 1'b0;
        e_repeat = 1'b0;
        e_held   = 1'b0;
    endtask

    // Events follow from the press length: long at LongTicks, repeats every
    // RepeatTicks beyond that, short on a release before LongTicks.
    task automatic model_step(input bit ena, input bit b);
        e_short  = 1'b0;
        e_long   = 1'b0;
        e_repeat = 1'b0;
        if (ena) begin
            if (!m_armed) begin
                if (!b) m_armed = 1'b1;
            end else if (!b) begin
                if (hold_n > 0 && hold_n < LongTicks) e_short = 1'b1;
                hold_n = 0;
            end else begin
                hold_n++;
                if (hold_n == LongTicks) e_long = 1'b1;
                else if (hold_n > LongTicks && (hold_n - LongTicks) % RepeatTicks == 0)
                    e_repeat = 1'b1;
            end
        end
        e_held = (hold_n >= LongTicks);
    endtask

    task automatic do_clk(input bit ena, input bit b);
        @(negedge i_clk);
        i_ena = ena;
        i_btn = b;
        @(posedge i_clk);
        model_step(ena, b);
        #1;
        check_outputs("clk");
    endtask

    // One enable tick every fourth clock; noise toggles the button between ticks.
    task automatic tick(input bit b, input bit noise);
        for (int i = 0; i < 3; i++) begin
            do_clk(1'b0, noise ? 1'($urandom_range(0, 1)) : b);
        end
        do_clk(1'b1, b);
    endtask

    task automatic ticks(input bit b, input int n);
        for (int i = 0; i < n; i++) tick(b, 1'b0);
    endtask

    // Reset asserted between edges must clear outputs at once, with ticks still arriving.
    task automatic do_reset(input bit b);
        @(negedge i_clk);
        i_btn = b;
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_ena = (i == 1);
            @(posedge i_clk);
            #1;
            check_outputs("rst_hold");
        end
        @(negedge i_clk);
        i_ena   = 1'b0;
        #2;
        i_rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_ena    = 1'b0;
        i_btn    = 1'b0;
        i_rst_n  = 1'b1;
        model_reset();

        // Idle reset, one low tick arms the decoder, then a press is accepted.
        do_reset(1'b0);
        ticks(1'b0, 1);
        ticks(1'b1, 2);
        ticks(1'b0, 1);

        // Short press of two ticks.
        ticks(1'b1, 2);
        ticks(1'b0, 2);

        // Long press with repeats after ticks 6 and 8.
        ticks(1'b1, 8);
        ticks(1'b0, 2);

        // Release on the threshold tick yields a short press.
        ticks(1'b1, 3);
        ticks(1'b0, 2);

        // Held across reset release: ignored until a low sample.
        do_reset(1'b1);
        ticks(1'b1, 10);
        ticks(1'b0, 1);
        ticks(1'b1, 1);
        ticks(1'b0, 2);

        // Button toggling only between ticks produces nothing.
        for (int i = 0; i < 16; i++) do_clk(1'b0, 1'($urandom_range(0, 1)));
        ticks(1'b0, 1);

        // Reset at tick 3 of a hold aborts the press; no long at tick 4.
        ticks(1'b1, 2);
        do_reset(1'b1);
        ticks(1'b1, 3);
        ticks(1'b0, 2);

        // Randomized presses with noise between ticks and occasional resets.
        for (int p = 0; p < 120; p++) begin
            int len;
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 15) == 0) do_reset(1'($urandom_range(0, 1)));
            for (int i = 0; i < len; i++) tick(1'b1, 1'b1);
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick(1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 The parameter LONG_TICKS SHALL default to 500 and SHALL set the number of held enable ticks that define a long press; its legal range is 2..65535.
REQ-002 The parameter REPEAT_TICKS SHALL default to 100 and SHALL set the number of held enable ticks between auto-repeat events; its legal range is 1..65535.
REQ-003 i_clk  input  1  system clock; all state SHALL change on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_ena  input  1  one-clock sample tick (nominal 2 ms); this is the same tick that drives the debouncer.
REQ-006 i_btn  input  1  debounced, synchronised button level; high means pressed.
REQ-007 o_short  output  1  one-clock pulse that marks a short press.
REQ-008 o_long  output  1  one-clock pulse that marks that the long-press threshold has been reached.
REQ-009 o_repeat  output  1  one-clock pulse that marks an auto-repeat event while the button is held after a long press.
REQ-010 o_held  output  1  level, high while in state REPEAT.

Function
REQ-011 State SHALL advance only on i_clk edges where i_ena=1; when i_ena=0, state and counter SHALL hold and all pulse outputs SHALL be 0.
REQ-012 o_short, o_long and o_repeat SHALL be registered, SHALL be exactly one i_clk cycle wide, and SHALL assert in the cycle after the qualifying i_ena edge; at most one of them SHALL be high in any cycle.
REQ-013 The FSM SHALL have four states: ARM, IDLE, PRESS, REPEAT.
REQ-014 The hold counter SHALL be 16 bits wide, unsigned, and SHALL never wrap.
REQ-015 ARM: on a tick with i_btn=0, go to IDLE; on a tick with i_btn=1, remain in ARM. No event SHALL be generated in ARM.
REQ-016 IDLE: on a tick with i_btn=1, go to PRESS with cnt=1; on a tick with i_btn=0, remain in IDLE.
REQ-017 PRESS, tick with i_btn=0: pulse o_short and go to IDLE.
REQ-018 PRESS, tick with i_btn=1 and cnt==LONG_TICKS-1: pulse o_long, go to REPEAT, and set cnt=0. This means o_long fires on the LONG_TICKS-th held tick.
REQ-019 PRESS, tick with i_btn=1 and cnt<LONG_TICKS-1: increment cnt.
REQ-020 REPEAT, tick with i_btn=1: if cnt==REPEAT_TICKS-1, pulse o_repeat and set cnt=0; otherwise increment cnt.
REQ-021 REPEAT, tick with i_btn=0: go to IDLE with no pulse; a long press SHALL never also yield o_short.
REQ-022 When a release coincides with the threshold tick (i_btn=0 on what would be tick LONG_TICKS), the release SHALL win: o_short fires and o_long does not.
REQ-023 With REPEAT_TICKS=1, o_repeat SHALL pulse on every held tick after o_long.
REQ-024 A button held high through reset deassertion SHALL produce no event until i_btn has been sampled low at least once.

Reset
REQ-025 On i_rst_n=0, the block SHALL immediately and asynchronously force: state=ARM, cnt=0, o_short=0, o_long=0, o_repeat=0, o_held=0.
REQ-026 Reset asserted mid-hold SHALL abort the press with no pulse at assertion or at deassertion.
REQ-027 Operation SHALL resume on the first i_ena tick after i_rst_n returns high.

Verification (bench parameters LONG_TICKS=4, REPEAT_TICKS=2; i_ena every 4th clock)
REQ-028 Reset with i_btn=0, then 1 tick -> all outputs 0 throughout; a following press is accepted (state IDLE).
REQ-029 i_btn=1 for ticks 1-2, 0 on tick 3 -> o_short high exactly 1 clock after tick 3; o_long and o_repeat never assert.
REQ-030 i_btn=1 for ticks 1-8, then 0 -> o_long after tick 4; o_repeat after ticks 6 and 8; o_held high from tick 4 until after release; o_short never asserts.
REQ-031 i_btn=1 on ticks 1-3, 0 on tick 4 -> o_short only, after tick 4 (boundary case).
REQ-032 i_btn=1 across reset release for 10 ticks, then 0 for 1 tick, then 1 for 1 tick, then 0 -> no events during the 10 ticks; o_short after the final release.
REQ-033 Two cases: (a) i_btn toggles while i_ena=0 -> no outputs; (b) i_rst_n pulsed low at tick 3 of a hold -> all outputs 0 and no o_long at tick 4.
